// File: rtl/sparse_spmm_scheduler_pkg.sv
// Shared definitions for the sparse SpMM scheduler.
// Contents: default word/index widths, job FSM state encoding, and a
// width helper used to size counters and pointers.
package sparse_spmm_scheduler_pkg;

  localparam int DEF_DATA_BITS = 16;
  localparam int DEF_ROW_BITS  = 7;
  localparam int DEF_COL_BITS  = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_FIN
  } state_t;

  // ceil(log2(n)), never less than 1 so it can always size a vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sched_tag_fifo.sv
// Row-tag FIFO: holds row indices of dispatched rows until the PEs return
// their results. First-word-fall-through read port.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty.
// Push and pop in the same cycle are both performed; push when full and
// pop when empty are dropped.
module sched_tag_fifo
  import sparse_spmm_scheduler_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr, rd_ptr;

  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sparse_spmm_scheduler.sv
// Sparse x dense matrix multiply scheduler.
// Streams CSR-ordered nonzeros to NUM_PE external MAC PEs, one weight column
// per PE, over W_COLS/NUM_PE column passes. Weight banks are reloaded at the
// start of each pass.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_start             start a job (IDLE only)
//   i_w_* / o_w_rdy     weight stream, column-major within a pass
//   i_nz_* / o_nz_rdy   nonzero stream
//   o_pe_*              operand/weight broadcast to the PEs
//   i_pe_done/result    PE results for the oldest outstanding row
//   o_valid/o_result/o_row_idx/o_col_base  output row segment
//   o_busy, o_done, o_err  status
module sparse_spmm_scheduler
  import sparse_spmm_scheduler_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int NUM_PE    = 2,
  parameter int W_ROWS    = 32,
  parameter int W_COLS    = 8,
  parameter int ROW_BITS  = DEF_ROW_BITS,
  parameter int COL_BITS  = DEF_COL_BITS,
  parameter int TAG_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_w_vld,
  output logic                          o_w_rdy,
  input  logic [DATA_BITS-1:0]          i_w_data,
  input  logic                          i_nz_vld,
  output logic                          o_nz_rdy,
  input  logic [DATA_BITS-1:0]          i_nz_data,
  input  logic [ROW_BITS-1:0]           i_nz_row,
  input  logic [COL_BITS-1:0]           i_nz_col,
  input  logic                          i_nz_row_last,
  input  logic                          i_nz_mat_last,
  output logic                          o_pe_vld,
  output logic                          o_pe_ctrl,
  output logic                          o_pe_flush,
  output logic [DATA_BITS-1:0]          o_pe_data,
  output logic [NUM_PE*DATA_BITS-1:0]   o_pe_weight,
  input  logic                          i_pe_done,
  input  logic [NUM_PE*DATA_BITS-1:0]   i_pe_result,
  output logic                          o_valid,
  output logic [NUM_PE*DATA_BITS-1:0]   o_result,
  output logic [ROW_BITS-1:0]           o_row_idx,
  output logic [clog2(W_COLS)-1:0]      o_col_base,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int NPASS     = W_COLS / NUM_PE;
  localparam int PASS_BITS = clog2(NPASS);
  localparam int PE_BITS   = clog2(NUM_PE);
  localparam int CB_BITS   = clog2(W_COLS);

  state_t               state;
  logic [PASS_BITS-1:0] pass;
  logic [COL_BITS-1:0]  wrow;
  logic [PE_BITS-1:0]   wcol;
  logic                 first;      // next accepted nonzero is first of pass
  logic                 prev_last;  // previous accepted nonzero closed a row

  logic [DATA_BITS-1:0] bank [NUM_PE][W_ROWS];

  logic                 fifo_full, fifo_empty;
  logic [ROW_BITS-1:0]  tag_dout;

  logic w_hs, accept, tag_push, tag_pop, col_ok;

  assign o_w_rdy  = (state == S_LOAD);
  assign o_nz_rdy = (state == S_COMPUTE) && !fifo_full;
  assign o_busy   = (state != S_IDLE);
  assign w_hs     = i_w_vld && o_w_rdy;
  assign accept   = i_nz_vld && o_nz_rdy;
  assign tag_push = accept && i_nz_row_last;
  assign tag_pop  = i_pe_done && !fifo_empty;
  // Columns beyond the loaded weight rows multiply by zero.
  assign col_ok   = int'(i_nz_col) < W_ROWS;

  sched_tag_fifo #(.WIDTH(ROW_BITS), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (i_nz_row),
    .pop   (tag_pop),
    .dout  (tag_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Banks are never cleared; handshake k lands in bank[k/W_ROWS][k%W_ROWS].
  always_ff @(posedge clk) begin
    if (w_hs && !rst) bank[wcol][wrow] <= i_w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pass        <= '0;
      wrow        <= '0;
      wcol        <= '0;
      first       <= 1'b0;
      prev_last   <= 1'b0;
      o_pe_vld    <= 1'b0;
      o_pe_ctrl   <= 1'b0;
      o_pe_flush  <= 1'b0;
      o_pe_data   <= '0;
      o_pe_weight <= '0;
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_row_idx   <= '0;
      o_col_base  <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      // Dispatch stage: one registered operand per accepted nonzero.
      o_pe_vld   <= accept;
      o_pe_data  <= accept ? i_nz_data : '0;
      o_pe_flush <= accept && i_nz_row_last;
      o_pe_ctrl  <= accept && !(first || prev_last);
      for (int k = 0; k < NUM_PE; k++)
        o_pe_weight[k*DATA_BITS +: DATA_BITS] <= (accept && col_ok) ? bank[k][i_nz_col] : '0;
      if (accept) begin
        first     <= 1'b0;
        prev_last <= i_nz_row_last;
      end

      // Result stage: pair returned PE results with the oldest row tag.
      o_valid <= tag_pop;
      if (tag_pop) begin
        o_result   <= i_pe_result;
        o_row_idx  <= tag_dout;
        o_col_base <= CB_BITS'(int'(pass) * NUM_PE);
      end
      if (i_pe_done && fifo_empty) o_err <= 1'b1;

      o_done <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          state <= S_LOAD;
          pass  <= '0;
          wrow  <= '0;
          wcol  <= '0;
        end
        S_LOAD: if (w_hs) begin
          if (wrow == COL_BITS'(W_ROWS-1)) begin
            wrow <= '0;
            if (wcol == PE_BITS'(NUM_PE-1)) begin
              wcol  <= '0;
              first <= 1'b1;
              state <= S_COMPUTE;
            end else begin
              wcol <= wcol + PE_BITS'(1);
            end
          end else begin
            wrow <= wrow + COL_BITS'(1);
          end
        end
        S_COMPUTE: if (accept && i_nz_mat_last) state <= S_DRAIN;
        // o_pe_vld high means the last dispatch has not left yet.
        S_DRAIN: if (fifo_empty && !o_pe_vld) begin
          if (pass == PASS_BITS'(NPASS-1)) begin
            state <= S_FIN;
          end else begin
            pass  <= pass + PASS_BITS'(1);
            state <= S_LOAD;
          end
        end
        S_FIN: begin
          o_done <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
